// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parameterised VGA horizontal/vertical timing generator driven by a pixel tick
module vga_sync_gen #(
  parameter int CNT_W     = 12,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  generate
    if (H_TOTAL > 2 ** CNT_W || V_TOTAL > 2 ** CNT_W) begin : g_size_check
      $error("vga_sync_gen: timing totals do not fit in CNT_W bits");
    end
  endgenerate
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  logic             h_wrap, v_wrap;
  logic [CNT_W-1:0] h_n, v_n;
  // next position; decoding from it keeps every output aligned with pixel_x/pixel_y
  always_comb begin
    h_wrap = pix_tick && pixel_x == H_LAST;
    v_wrap = h_wrap && pixel_y == V_LAST;
    h_n    = h_wrap ? '0 : pixel_x + CNT_W'(pix_tick);
    v_n    = v_wrap ? '0 : pixel_y + CNT_W'(h_wrap);
  end
  // position counters and registered decode of the next position
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= h_n;
      pixel_y     <= v_n;
      hsync       <= (h_n >= HS_START && h_n <= HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_n >= VS_START && v_n <= VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on    <= h_n < H_VIS && v_n < V_VIS;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized check of two vga_sync_gen instances against a tick-count reference model
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_a = 1'b0, tick_b = 1'b0;
  logic hs_a, vs_a, vo_a, ls_a, fs_a;
  logic hs_b, vs_b, vo_b, ls_b, fs_b;
  logic [11:0] x_a, y_a, x_b, y_b;
  int n_chk = 0, n_fail = 0;
  longint t_a = 0, t_b = 0;
  bit rs_a = 1, rs_b = 1, tk_a = 0, tk_b = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_dflt (
    .clk(clk), .rst(rst), .pix_tick(tick_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .pixel_x(x_a), .pixel_y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk(clk), .rst(rst), .pix_tick(tick_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .pixel_x(x_b), .pixel_y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // model: position is just the tick count since reset, folded by the line and frame totals
  task automatic check_inst(input string p, input int hv, input int hf, input int hsw, input int hb,
                            input int vv, input int vf, input int vsw, input int vb,
                            input longint t, input bit rs, input bit tk,
                            input logic [11:0] x, input logic [11:0] y, input logic hsy,
                            input logic vsy, input logic vo, input logic ls, input logic fs);
    int ht, vt, ex, ey;
    bit ehs, evs, evo, els, efs;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    ex  = rs ? 0 : int'(t % ht);
    ey  = rs ? 0 : int'((t / ht) % vt);
    ehs = !(!rs && ex >= hv + hf && ex < hv + hf + hsw);
    evs = !(!rs && ey >= vv + vf && ey < vv + vf + vsw);
    evo = !rs && ex < hv && ey < vv;
    els = !rs && tk && ex == 0;
    efs = els && ey == 0;
    chk({p, "_pixel_x"}, 32'(x), 32'(ex));
    chk({p, "_pixel_y"}, 32'(y), 32'(ey));
    chk({p, "_hsync"}, 32'(hsy), 32'(ehs));
    chk({p, "_vsync"}, 32'(vsy), 32'(evs));
    chk({p, "_video_on"}, 32'(vo), 32'(evo));
    chk({p, "_line_start"}, 32'(ls), 32'(els));
    chk({p, "_frame_start"}, 32'(fs), 32'(efs));
  endtask

  task automatic cyc(input bit r, input bit ta, input bit tb);
    rst = r;
    tick_a = ta;
    tick_b = tb;
    @(posedge clk);
    rs_a = r; rs_b = r; tk_a = ta; tk_b = tb;
    if (r) begin
      t_a = 0;
      t_b = 0;
    end else begin
      t_a += ta;
      t_b += tb;
    end
    @(negedge clk);
    check_inst("dflt", 640, 16, 96, 48, 480, 10, 2, 33, t_a, rs_a, tk_a,
               x_a, y_a, hs_a, vs_a, vo_a, ls_a, fs_a);
    check_inst("small", 8, 2, 2, 2, 4, 1, 1, 1, t_b, rs_b, tk_b,
               x_b, y_b, hs_b, vs_b, vo_b, ls_b, fs_b);
  endtask

  initial begin
    bit found;
    int hs_low;
    for (int i = 0; i < 3; i++) cyc(1, 1, 1);
    cyc(0, 0, 1);
    chk("release_video_on", 32'(vo_a), 32'd1);
    // default timing, one tick every fourth clock, small instance free-running
    hs_low = 0;
    for (int i = 0; i < 6400; i++) begin
      cyc(0, i % 4 == 3, 1);
      if (i % 4 == 3 && hs_a == 1'b0) hs_low++;
    end
    chk("hsync_low_ticks", 32'(hs_low), 32'd192);
    // stop the default instance mid-line at pixel_x 100
    found = 0;
    for (int i = 0; i < 900 && !found; i++) begin
      if (t_a % 800 == 100) found = 1;
      else cyc(0, 1, 1);
    end
    chk("reach_x100", 32'(found), 32'd1);
    for (int i = 0; i < 50; i++) cyc(0, 0, 32'($urandom_range(0, 1)));
    chk("gated_x", 32'(x_a), 32'd100);
    for (int i = 0; i < 4000; i++) cyc(0, 32'($urandom_range(0, 1)) != 0, $urandom_range(0, 3) != 0);
    // small instance: reach the last position and wrap to (0,0)
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (t_b % 98 == 97) found = 1;
      else cyc(0, 0, 1);
    end
    chk("reach_last", 32'(found), 32'd1);
    cyc(0, 0, 1);
    chk("wrap_frame_start", 32'(fs_b), 32'd1);
    chk("wrap_line_start", 32'(ls_b), 32'd1);
    cyc(0, 0, 0);
    chk("wrap_fs_clear", 32'(fs_b), 32'd0);
    // mid-frame reset with a tick present at (5,2)
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (t_b % 98 == 33) found = 1;
      else cyc(0, 1, 1);
    end
    chk("reach_mid", 32'(found), 32'd1);
    cyc(1, 1, 1);
    chk("midrst_x", 32'(x_b), 32'd0);
    chk("midrst_fs", 32'(fs_b), 32'd0);
    for (int i = 0; i < 300; i++) cyc(0, 32'($urandom_range(0, 1)) != 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Horizontal/vertical timing generator for the VGA output path, directly downstream of the pixel-rate counter. It consumes the single-cycle `pix_tick` strobe derived from the counter and maintains the horizontal (dot) and vertical (line) position counters. From those it produces registered hsync/vsync, the active-video flag, the current pixel coordinates, and line/frame start pulses for the framebuffer reader. All timing values are parameters, and the defaults give 640x480@60 Hz.

## Interface
Parameters:
- `CNT_W`, 12, width of the position counters and of `pixel_x`/`pixel_y`
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (ticks)
- `H_SYNC`, 96, hsync pulse width (ticks)
- `H_BP`, 48, horizontal back porch (ticks)
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `pix_tick`  in  1  one-cycle pixel-advance strobe
- `hsync`  out  1  horizontal sync, registered
- `vsync`  out  1  vertical sync, registered
- `video_on`  out  1  high while the position is inside the visible area
- `pixel_x`  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- `pixel_y`  out  CNT_W  current vertical position, 0..V_TOTAL-1
- `line_start`  out  1  one-cycle pulse when `pixel_x` wraps to 0
- `frame_start`  out  1  one-cycle pulse when (`pixel_x`,`pixel_y`) wraps to (0,0)

## Operation
- Totals:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
  - Both totals must be ≤ 2^CNT_W; this is enforced with an elaboration-time check.
- Horizontal counter `h`:
  - Advances only on cycles with `pix_tick`=1.
  - h = H_TOTAL-1 with a tick → h=0 and the vertical counter advances.
  - Otherwise h+1.
- Vertical counter `v`:
  - Advances only when h wraps.
  - v = V_TOTAL-1 at that point → v=0.
  - Otherwise v+1.
- Decode uses the next-state counter values (h', v'), so all outputs are coherent with `pixel_x`/`pixel_y` in the same cycle:
  - hsync asserted for H_VISIBLE+H_FP ≤ h' ≤ H_VISIBLE+H_FP+H_SYNC-1 (default 656..751).
  - vsync asserted for V_VISIBLE+V_FP ≤ v' ≤ V_VISIBLE+V_FP+V_SYNC-1 (default 490..491).
  - video_on = (h' < H_VISIBLE) && (v' < V_VISIBLE).
- Pulses:
  - `line_start`=1 only in the cycle after a tick that wrapped h.
  - `frame_start`=1 only in the cycle after a tick that wrapped both h and v. `line_start` is also 1 in that cycle.
- With no tick, all outputs hold, except that `line_start`/`frame_start` return to 0.
- No FSM beyond the two counters. The decoded outputs are plain registers.

## Timing
- Reset values (while `rst`=1, at the clock edge):
  - h=v=0, `pixel_x`=`pixel_y`=0.
  - hsync=vsync=~SYNC_POL (deasserted).
  - `video_on`=0, `line_start`=`frame_start`=0.
- First cycle after `rst` deasserts, with or without a tick: `video_on`=1, reflecting (0,0) or (1,0).
- Latency: a tick sampled at edge N changes `pixel_x` and every decoded output at edge N, visible in cycle N+1. There is no further pipeline skew.
- `pix_tick` held high continuously is legal: one pixel per clock.
- `rst` asserted mid-frame takes priority over `pix_tick` in the same cycle. Counters return to (0,0) with no `frame_start` pulse.
- Boundary: (h,v)=(H_TOTAL-1,V_TOTAL-1) plus a tick → (0,0) with `frame_start`=`line_start`=1 for exactly one cycle.
- Sync edges occur exactly at tick boundaries. Each hsync pulse spans H_SYNC ticks; each vsync pulse spans V_SYNC·H_TOTAL ticks.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `pix_tick`=1 → `pixel_x`=`pixel_y`=0, hsync=vsync=1, `video_on`=0, pulses 0; cycle after release → `video_on`=1.
- Default params, `pix_tick` every 4th clk:
  - hsync low for exactly 96 ticks starting when `pixel_x`=656.
  - Line period 800 ticks = 3200 clk.
  - `video_on` low from `pixel_x`=640.
- Small params (H 8/2/2/2, V 4/1/1/1), `pix_tick`=1 constantly:
  - `line_start` every 14 clk.
  - `frame_start` every 98 clk.
  - vsync low for 14 clk while `pixel_y`=5.
- Wrap: run to (H_TOTAL-1,V_TOTAL-1) and apply one tick → next cycle (0,0) with `frame_start`=1 and `line_start`=1; following cycle both 0.
- Tick gating: hold `pix_tick`=0 for 50 clk mid-line at `pixel_x`=100 → all outputs unchanged and no pulses.
- Mid-frame reset: at (300,200) assert `rst` together with `pix_tick` → next cycle (0,0), sync deasserted, `frame_start`=0.
